// File: rtl/udma_sdio_seq_pkg.sv
// Shared types and constants for the SDIO command sequencer.
// The descriptor layout is the same for queued and injected commands.
package udma_sdio_seq_pkg;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] arg;
    logic [2:0]  rsp_type;
    logic        data_en;
    logic        data_rwn;
  } sdio_desc_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT       = 3'd2,
    S_RETRY      = 3'd3,
    S_HALT       = 3'd4,
    S_STOP_ISSUE = 3'd5
  } seq_state_e;

  localparam int          RETRY_GAP      = 8;
  localparam logic [15:0] TIMEOUT_STATUS = 16'h8000;
  localparam logic [5:0]  CMD12_OP       = 6'd12;
  localparam logic [2:0]  RSP_R1B        = 3'd4;

  // STOP_TRANSMISSION descriptor injected after a multi-block data command.
  function automatic sdio_desc_t stop_desc();
    sdio_desc_t d;
    d.op       = CMD12_OP;
    d.arg      = 32'h0000_0000;
    d.rsp_type = RSP_R1B;
    d.data_en  = 1'b0;
    d.data_rwn = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/udma_sdio_desc_fifo.sv
// Descriptor queue: synchronous FIFO with flush, allowing push while full
// when a pop happens in the same cycle.
module udma_sdio_desc_fifo
  import udma_sdio_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       push_i,
  input  sdio_desc_t wdata_i,
  input  logic       pop_i,
  output sdio_desc_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  sdio_desc_t    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop_i && (count_r != '0);
  assign do_push_s = push_i && ((count_r != FULL_CNT) || do_pop_s);

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata_i;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata_o = mem_r[rd_ptr_r];
  assign full_o  = (count_r == FULL_CNT);
  assign empty_o = (count_r == '0);

endmodule

// File: rtl/udma_sdio_cmd_seq.sv
// SDIO command sequencer: queues descriptors and issues them to the txrx engine
// with retry and watchdog. Optional CMD12 auto-stop via UDMA_SDIO_SEQ_AUTOSTOP_EN.
module udma_sdio_cmd_seq
  import udma_sdio_seq_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_RETRY = 3,
  parameter logic [15:0] ERR_MASK  = 16'h00FF,
  parameter int          TIMEOUT_W = 20
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [5:0]           desc_op_i,
  input  logic [31:0]          desc_arg_i,
  input  logic [2:0]           desc_rsp_type_i,
  input  logic                 desc_data_en_i,
  input  logic                 desc_data_rwn_i,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  output logic                 txrx_start_o,
  output logic [5:0]           txrx_cmd_op_o,
  output logic [31:0]          txrx_cmd_arg_o,
  output logic [2:0]           txrx_cmd_rsp_type_o,
  output logic                 txrx_data_en_o,
  output logic                 txrx_data_rwn_o,
  input  logic                 txrx_eot_i,
  input  logic [15:0]          txrx_status_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [15:0]          last_status_o,
  output logic [1:0]           retry_cnt_o
);
  localparam int RW = ($clog2(MAX_RETRY + 2) > 2) ? $clog2(MAX_RETRY + 2) : 2;
  localparam int GW = $clog2(RETRY_GAP);

  seq_state_e           state_r, state_n;
  sdio_desc_t           cmd_r, cmd_n, push_desc_s, head_s;
  logic [RW-1:0]        retry_r, retry_n;
  logic [TIMEOUT_W-1:0] wd_r, wd_n;
  logic [GW-1:0]        gap_r, gap_n;
  logic [15:0]          status_r, status_n;
  logic                 start_r, done_r, err_r, ready_en_r;
  logic                 done_n, err_n;
  logic                 full_s, empty_s, push_s, pop_s, wd_exp_s, autostop_s;

  assign push_desc_s = '{op: desc_op_i, arg: desc_arg_i, rsp_type: desc_rsp_type_i,
                         data_en: desc_data_en_i, data_rwn: desc_data_rwn_i};
  assign push_s      = desc_valid_i && desc_ready_o;

  udma_sdio_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (clr_i),
    .push_i  (push_s),
    .wdata_i (push_desc_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign wd_exp_s = (cfg_timeout_i != '0) && (wd_r == (cfg_timeout_i - TIMEOUT_W'(1)));

`ifdef UDMA_SDIO_SEQ_AUTOSTOP_EN
  assign autostop_s = cmd_r.data_en && ((cmd_r.op == 6'd18) || (cmd_r.op == 6'd25));
`else
  assign autostop_s = 1'b0;
`endif

  // Next-state and next-register values; clr_i overrides everything.
  always_comb begin
    state_n  = state_r;
    cmd_n    = cmd_r;
    retry_n  = retry_r;
    wd_n     = wd_r;
    gap_n    = gap_r;
    status_n = status_r;
    done_n   = 1'b0;
    err_n    = 1'b0;
    pop_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          cmd_n   = head_s;
          retry_n = '0;
          state_n = S_ISSUE;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ISSUE: begin
        wd_n    = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        wd_n = wd_r + TIMEOUT_W'(1);
        // eot beats a watchdog expiry in the same cycle
        if (txrx_eot_i || wd_exp_s) begin
          status_n = txrx_eot_i ? txrx_status_i : TIMEOUT_STATUS;
          if (txrx_eot_i && ((txrx_status_i & ERR_MASK) == 16'h0000)) begin
            if (autostop_s) begin
              state_n = S_STOP_ISSUE;
            end else begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
          end else if (retry_r < RW'(MAX_RETRY)) begin
            retry_n = retry_r + RW'(1);
            gap_n   = '0;
            state_n = S_RETRY;
          end else begin
            err_n   = 1'b1;
            state_n = S_HALT;
          end
        end else begin
          state_n = S_WAIT;
        end
      end
      S_RETRY: begin
        if (gap_r == GW'(RETRY_GAP - 1)) begin
          state_n = S_ISSUE;
        end else begin
          gap_n = gap_r + GW'(1);
        end
      end
      S_STOP_ISSUE: begin
        cmd_n   = stop_desc();
        retry_n = '0;
        state_n = S_ISSUE;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
    if (clr_i) begin
      state_n = S_IDLE;
      cmd_n   = cmd_r;
      retry_n = '0;
      wd_n    = '0;
      gap_n   = '0;
      pop_s   = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end else begin
      state_n = state_n;
    end
  end

  // State, held command, counters and registered event outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r    <= S_IDLE;
      cmd_r      <= '0;
      retry_r    <= '0;
      wd_r       <= '0;
      gap_r      <= '0;
      status_r   <= '0;
      start_r    <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      ready_en_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      cmd_r      <= cmd_n;
      retry_r    <= retry_n;
      wd_r       <= wd_n;
      gap_r      <= gap_n;
      status_r   <= status_n;
      start_r    <= (state_n == S_ISSUE);
      done_r     <= done_n;
      err_r      <= err_n;
      ready_en_r <= 1'b1;
    end
  end

  assign desc_ready_o        = ready_en_r && (!full_s || pop_s);
  assign txrx_start_o        = start_r;
  assign txrx_cmd_op_o       = cmd_r.op;
  assign txrx_cmd_arg_o      = cmd_r.arg;
  assign txrx_cmd_rsp_type_o = cmd_r.rsp_type;
  assign txrx_data_en_o      = cmd_r.data_en;
  assign txrx_data_rwn_o     = cmd_r.data_rwn;
  assign busy_o              = (state_r != S_IDLE) || !empty_s;
  assign done_o              = done_r;
  assign err_o               = err_r;
  assign last_status_o       = status_r;
  assign retry_cnt_o         = (retry_r > RW'(3)) ? 2'd3 : retry_r[1:0];

endmodule

// File: tb/tb_udma_sdio_cmd_seq.sv
// Directed bench for udma_sdio_cmd_seq: ordering, retry, halt/clear,
// watchdog, queue-full back-pressure and (when enabled) CMD12 auto-stop.
module tb_udma_sdio_cmd_seq;
  logic        clk;
  logic        rstn;
  logic        clr;
  logic        desc_valid;
  logic        desc_ready;
  logic [5:0]  desc_op;
  logic [31:0] desc_arg;
  logic [2:0]  desc_rsp;
  logic        desc_den;
  logic        desc_rwn;
  logic [19:0] cfg_timeout;
  logic        start;
  logic [5:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [2:0]  cmd_rsp;
  logic        data_en;
  logic        data_rwn;
  logic        eot;
  logic [15:0] status;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] last_status;
  logic [1:0]  retry_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int seen = 0;
  logic [5:0]  st_op[$];
  logic [31:0] st_arg[$];
  logic [2:0]  st_rsp[$];
  int          st_cyc[$];
  logic [5:0]  cur_op;
  logic [31:0] cur_arg;
  logic [2:0]  cur_rsp;
  int          cur_cyc;

  udma_sdio_cmd_seq dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .clr_i               (clr),
    .desc_valid_i        (desc_valid),
    .desc_ready_o        (desc_ready),
    .desc_op_i           (desc_op),
    .desc_arg_i          (desc_arg),
    .desc_rsp_type_i     (desc_rsp),
    .desc_data_en_i      (desc_den),
    .desc_data_rwn_i     (desc_rwn),
    .cfg_timeout_i       (cfg_timeout),
    .txrx_start_o        (start),
    .txrx_cmd_op_o       (cmd_op),
    .txrx_cmd_arg_o      (cmd_arg),
    .txrx_cmd_rsp_type_o (cmd_rsp),
    .txrx_data_en_o      (data_en),
    .txrx_data_rwn_o     (data_rwn),
    .txrx_eot_i          (eot),
    .txrx_status_i       (status),
    .busy_o              (busy),
    .done_o              (done),
    .err_o               (err),
    .last_status_o       (last_status),
    .retry_cnt_o         (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor: counts pulses and records each issued command.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (start) begin
      start_cnt <= start_cnt + 1;
      st_op.push_back(cmd_op);
      st_arg.push_back(cmd_arg);
      st_rsp.push_back(cmd_rsp);
      st_cyc.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] rsp,
                      input logic den, input logic rwn);
    logic rdy;
    int   n;
    desc_op = op; desc_arg = arg; desc_rsp = rsp; desc_den = den; desc_rwn = rwn;
    desc_valid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 300) begin
      rdy = desc_ready;
      tick();
      n++;
    end
    desc_valid = 1'b0;
    chk("push_accept", 32'(rdy), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (start_cnt <= seen && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(start_cnt > seen), 32'd1);
    if (start_cnt > seen) begin
      cur_op = st_op[seen]; cur_arg = st_arg[seen]; cur_rsp = st_rsp[seen]; cur_cyc = st_cyc[seen];
      seen++;
    end else begin
      cur_op = '1; cur_arg = '1; cur_rsp = '1; cur_cyc = -1;
    end
  endtask

  task automatic send_eot(input logic [15:0] st);
    eot = 1'b1;
    status = st;
    tick();
    eot = 1'b0;
    status = 16'h0000;
  endtask

  int d0, e0, s0, s1;
  logic [5:0]  ops[3];
  logic [31:0] args[3];

  initial begin
    rstn = 1'b0; clr = 1'b0; desc_valid = 1'b0; desc_op = '0; desc_arg = '0; desc_rsp = '0;
    desc_den = 1'b0; desc_rwn = 1'b0; cfg_timeout = '0; eot = 1'b0; status = '0;
    ops[0] = 6'd0;  args[0] = 32'h0000_0000;
    ops[1] = 6'd8;  args[1] = 32'h0000_01AA;
    ops[2] = 6'd55; args[2] = 32'h1234_0000;
    repeat (3) tick();
    chk("rst_ready", 32'(desc_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();
    chk("idle_ready", 32'(desc_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_status", 32'(last_status), 32'd0);
    chk("idle_retry", 32'(retry_cnt), 32'd0);

    // 1: three commands complete in order
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) push(ops[i], args[i], 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_start("t1_start");
      chk("t1_op", 32'(cur_op), 32'(ops[i]));
      chk("t1_arg", cur_arg, args[i]);
      repeat (2) tick();
      chk("t1_busy", 32'(busy), 32'd1);
      send_eot(16'h0000);
    end
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_done", 32'(done_cnt - d0), 32'd3);

    // 2: two error attempts then success
    d0 = done_cnt; e0 = err_cnt;
    push(6'd17, 32'h0000_0200, 3'd1, 1'b1, 1'b1);
    wait_start("t2_start0");
    chk("t2_den", 32'(data_en), 32'd1);
    chk("t2_rwn", 32'(data_rwn), 32'd1);
    s0 = cur_cyc;
    repeat (3) tick();
    send_eot(16'h0001);
    chk("t2_retry1", 32'(retry_cnt), 32'd1);
    chk("t2_status1", 32'(last_status), 32'h0001);
    wait_start("t2_start1");
    chk("t2_gap1", 32'(cur_cyc - s0), 32'd12);
    chk("t2_op_same", 32'(cur_op), 32'd17);
    s0 = cur_cyc;
    repeat (3) tick();
    send_eot(16'h0001);
    wait_start("t2_start2");
    chk("t2_gap2", 32'(cur_cyc - s0), 32'd12);
    repeat (3) tick();
    send_eot(16'h0000);
    chk("t2_retry2", 32'(retry_cnt), 32'd2);
    chk("t2_done", 32'(done_cnt - d0), 32'd1);
    chk("t2_err", 32'(err_cnt - e0), 32'd0);

    // 3: persistent error, halt, then clear
    d0 = done_cnt; e0 = err_cnt;
    push(6'd24, 32'hCAFE_0000, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_start("t3_start");
      repeat (3) tick();
      send_eot(16'h0002);
    end
    chk("t3_err", 32'(err_cnt - e0), 32'd1);
    chk("t3_retry", 32'(retry_cnt), 32'd3);
    chk("t3_status", 32'(last_status), 32'h0002);
    s1 = start_cnt;
    push(6'd9, 32'h0000_0009, 3'd2, 1'b0, 1'b0);
    repeat (30) tick();
    chk("t3_halt_nostart", 32'(start_cnt), 32'(s1));
    chk("t3_halt_busy", 32'(busy), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_clr_busy", 32'(busy), 32'd0);
    chk("t3_clr_retry", 32'(retry_cnt), 32'd0);
    repeat (10) tick();
    chk("t3_clr_nostart", 32'(start_cnt), 32'(s1));
    chk("t3_done", 32'(done_cnt - d0), 32'd0);

    // 4: watchdog expiry, then eot coinciding with expiry
    d0 = done_cnt;
    cfg_timeout = 20'd100;
    push(6'd7, 32'h0000_0000, 3'd0, 1'b0, 1'b0);
    wait_start("t4_start0");
    s0 = cur_cyc;
    repeat (100) tick();
    chk("t4_pre_retry", 32'(retry_cnt), 32'd0);
    chk("t4_pre_status", 32'(last_status), 32'h0002);
    tick();
    chk("t4_to_retry", 32'(retry_cnt), 32'd1);
    chk("t4_to_status", 32'(last_status), 32'h8000);
    wait_start("t4_start1");
    chk("t4_gap", 32'(cur_cyc - s0), 32'd109);
    repeat (100) tick();
    send_eot(16'h0000);
    chk("t4_eot_wins_done", 32'(done_cnt - d0), 32'd1);
    chk("t4_eot_wins_status", 32'(last_status), 32'h0000);
    chk("t4_eot_wins_retry", 32'(retry_cnt), 32'd1);
    cfg_timeout = '0;

    // 5: queue full back-pressure, then clear mid-WAIT with a late eot
    for (int i = 0; i < 5; i++) push(6'(40 + i), 32'(i), 3'd1, 1'b0, 1'b0);
    chk("t5_full_ready", 32'(desc_ready), 32'd0);
    s1 = start_cnt;
    desc_op = 6'd50; desc_arg = 32'h0000_0050; desc_valid = 1'b1;
    repeat (3) tick();
    chk("t5_held_ready", 32'(desc_ready), 32'd0);
    d0 = done_cnt;
    send_eot(16'h0000);
    chk("t5_pop_ready", 32'(desc_ready), 32'd1);
    tick();
    desc_valid = 1'b0;
    chk("t5_first_done", 32'(done_cnt - d0), 32'd1);
    seen = start_cnt - 1;
    wait_start("t5_start_b");
    chk("t5_op_b", 32'(cur_op), 32'd41);
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_busy", 32'(busy), 32'd0);
    d0 = done_cnt;
    s1 = start_cnt;
    send_eot(16'h0000);
    repeat (20) tick();
    chk("t5_late_eot_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_flushed", 32'(start_cnt), 32'(s1));
    seen = start_cnt;

`ifdef UDMA_SDIO_SEQ_AUTOSTOP_EN
    // 6: multi-block read gets an automatic CMD12
    d0 = done_cnt;
    push(6'd18, 32'h0000_1000, 3'd1, 1'b1, 1'b1);
    wait_start("t6_start_data");
    repeat (3) tick();
    send_eot(16'h0000);
    chk("t6_no_early_done", 32'(done_cnt - d0), 32'd0);
    wait_start("t6_start_stop");
    chk("t6_stop_op", 32'(cur_op), 32'd12);
    chk("t6_stop_arg", cur_arg, 32'd0);
    chk("t6_stop_rsp", 32'(cur_rsp), 32'd4);
    repeat (3) tick();
    send_eot(16'h0000);
    chk("t6_done", 32'(done_cnt - d0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
